// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// counter width and the error quotient pattern.
package divisor_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    localparam int unsigned DIV_N     = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_N + 1);
    localparam logic [DIV_N-1:0] QUOT_ERR = {DIV_N{1'b1}};

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divisor_datapath.sv
// A/Q/D registers, N+1-bit trial subtractor with restore mux and error compares.
// DIVISOR_SIGNED_EN adds magnitude/sign handling around the unsigned core.
module divisor_datapath
    import divisor_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_s,
    input  logic           step_s,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           div_zero_s,
    output logic           ovf_start_s,
    output logic [N-1:0]   fin_quot_s,
    output logic [N-1:0]   fin_rem_s,
    output logic           fin_ovf_s
);

    logic [N-1:0]   a_r;
    logic [N-1:0]   q_r;
    logic [N-1:0]   d_r;
    logic [2*N-1:0] dd_mag_s;
    logic [N-1:0]   dv_mag_s;
    logic [N:0]     ca_s;
    logic [N:0]     trial_s;
    logic [N-1:0]   a_nxt_s;
    logic [N-1:0]   q_nxt_s;

`ifdef DIVISOR_SIGNED_EN
    logic sdd_r;
    logic sdv_r;
    logic sgn_diff_s;

    assign dd_mag_s   = dividend[2*N-1] ? (-dividend) : dividend;
    assign dv_mag_s   = divisor[N-1] ? (-divisor) : divisor;
    assign sgn_diff_s = sdd_r ^ sdv_r;

    // Sign correction applied on the final write; a negative quotient may reach -2^(N-1)
    always_comb begin
        fin_quot_s = q_nxt_s;
        fin_rem_s  = a_nxt_s;
        fin_ovf_s  = 1'b0;
        if (sgn_diff_s) begin
            fin_quot_s = -q_nxt_s;
            fin_ovf_s  = (q_nxt_s > {1'b1, {(N-1){1'b0}}});
        end else begin
            fin_ovf_s  = q_nxt_s[N-1];
        end
        if (sdd_r) begin
            fin_rem_s = -a_nxt_s;
        end else begin
            fin_rem_s = a_nxt_s;
        end
    end

    // Operand signs captured on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdd_r <= 1'b0;
            sdv_r <= 1'b0;
        end else if (load_s) begin
            sdd_r <= dividend[2*N-1];
            sdv_r <= divisor[N-1];
        end else begin
            sdd_r <= sdd_r;
            sdv_r <= sdv_r;
        end
    end
`else
    assign dd_mag_s   = dividend;
    assign dv_mag_s   = divisor;
    assign fin_quot_s = q_nxt_s;
    assign fin_rem_s  = a_nxt_s;
    assign fin_ovf_s  = 1'b0;
`endif

    assign div_zero_s  = (divisor == {N{1'b0}});
    assign ovf_start_s = (dd_mag_s[2*N-1:N] >= dv_mag_s);

    // One restoring iteration: shift, trial subtract, keep result only if non-negative
    always_comb begin
        ca_s    = {a_r, q_r[N-1]};
        trial_s = ca_s - {1'b0, d_r};
        if (!trial_s[N]) begin
            a_nxt_s = trial_s[N-1:0];
            q_nxt_s = {q_r[N-2:0], 1'b1};
        end else begin
            a_nxt_s = ca_s[N-1:0];
            q_nxt_s = {q_r[N-2:0], 1'b0};
        end
    end

    // Partial remainder, quotient shift register and divisor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {N{1'b0}};
            q_r <= {N{1'b0}};
            d_r <= {N{1'b0}};
        end else if (load_s) begin
            a_r <= dd_mag_s[2*N-1:N];
            q_r <= dd_mag_s[N-1:0];
            d_r <= dv_mag_s;
        end else if (step_s) begin
            a_r <= a_nxt_s;
            q_r <= q_nxt_s;
            d_r <= d_r;
        end else begin
            a_r <= a_r;
            q_r <= q_r;
            d_r <= d_r;
        end
    end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider top: IDLE/CALC control FSM with registered results.
// Optional signed operation via macro DIVISOR_SIGNED_EN.
module divisor_sequencial
    import divisor_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           St,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quociente,
    output logic [N-1:0]   Resto,
    output logic           Idle,
    output logic           Done,
    output logic           DivZero,
    output logic           Overflow
);

    localparam int unsigned CNT_W = (N == DIV_N) ? DIV_CNT_W : cnt_width(N);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_s;
    logic             step_s;
    logic             div_zero_s;
    logic             ovf_start_s;
    logic [N-1:0]     fin_quot_s;
    logic [N-1:0]     fin_rem_s;
    logic             fin_ovf_s;

    // Datapath strobes decoded from the current state
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = St;
        end else begin
            step_s = 1'b1;
        end
    end

    divisor_datapath #(.N(N)) u_dp (
        .clk         (Clk),
        .rst_n       (Reset),
        .load_s      (load_s),
        .step_s      (step_s),
        .dividend    (Dividendo),
        .divisor     (Divisor),
        .div_zero_s  (div_zero_s),
        .ovf_start_s (ovf_start_s),
        .fin_quot_s  (fin_quot_s),
        .fin_rem_s   (fin_rem_s),
        .fin_ovf_s   (fin_ovf_s)
    );

    // Control FSM and result registers; error cases resolve on the start edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            Quociente <= {N{1'b0}};
            Resto     <= {N{1'b0}};
            Idle      <= 1'b1;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (St) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        Done     <= 1'b0;
                        DivZero  <= 1'b0;
                        Overflow <= 1'b0;
                        if (div_zero_s) begin
                            DivZero   <= 1'b1;
                            Done      <= 1'b1;
                            Quociente <= {N{1'b1}};
                            Resto     <= Dividendo[N-1:0];
                        end else if (ovf_start_s) begin
                            Overflow  <= 1'b1;
                            Done      <= 1'b1;
                            Quociente <= {N{1'b1}};
                            Resto     <= {N{1'b0}};
                        end else begin
                            state_r <= ST_CALC;
                            Idle    <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N - 1)) begin
                        state_r <= ST_IDLE;
                        Idle    <= 1'b1;
                        Done    <= 1'b1;
                        if (fin_ovf_s) begin
                            Overflow  <= 1'b1;
                            Quociente <= {N{1'b1}};
                            Resto     <= {N{1'b0}};
                        end else begin
                            Quociente <= fin_quot_s;
                            Resto     <= fin_rem_s;
                        end
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    Idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Randomized self-checking bench for divisor_sequencial against an arithmetic model.
// Signed cases are exercised when DIVISOR_SIGNED_EN is defined.
module tb_divisor_sequencial;
    import divisor_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        St;
    logic [31:0] Dividendo;
    logic [15:0] Divisor;
    logic [15:0] Quociente;
    logic [15:0] Resto;
    logic        Idle;
    logic        Done;
    logic        DivZero;
    logic        Overflow;

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic [31:0] exp_dd;
    logic [15:0] exp_dv;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_dz;
    logic        exp_ov;
    logic        exp_fast;

    divisor_sequencial #(.N(16)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .St        (St),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Quociente (Quociente),
        .Resto     (Resto),
        .Idle      (Idle),
        .Done      (Done),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (dd=0x%0h dv=0x%0h)", name, act, req, exp_dd, exp_dv);
        end
    endtask

    // Reference: plain division with the error rules applied on top
    function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov, output logic fast);
`ifdef DIVISOR_SIGNED_EN
        longint sdd;
        longint sdv;
        longint mdd;
        longint mdv;
        longint sq;
        longint sr;
        sdd = longint'($signed(dd));
        sdv = longint'($signed(dv));
        mdd = (sdd < 0) ? -sdd : sdd;
        mdv = (sdv < 0) ? -sdv : sdv;
        dz = 1'b0; ov = 1'b0; fast = 1'b0;
        if (dv == 16'd0) begin
            dz = 1'b1; fast = 1'b1; q = 16'hFFFF; r = dd[15:0];
        end else if ((mdd / 65536) >= mdv) begin
            ov = 1'b1; fast = 1'b1; q = 16'hFFFF; r = 16'h0000;
        end else begin
            sq = sdd / sdv;
            sr = sdd % sdv;
            if (sq < -32768 || sq > 32767) begin
                ov = 1'b1; q = 16'hFFFF; r = 16'h0000;
            end else begin
                q = 16'(sq); r = 16'(sr);
            end
        end
`else
        longint udd;
        longint udv;
        udd = longint'(dd);
        udv = longint'(dv);
        dz = 1'b0; ov = 1'b0; fast = 1'b0;
        if (dv == 16'd0) begin
            dz = 1'b1; fast = 1'b1; q = 16'hFFFF; r = dd[15:0];
        end else if ((udd / 65536) >= udv) begin
            ov = 1'b1; fast = 1'b1; q = 16'hFFFF; r = 16'h0000;
        end else begin
            q = 16'(udd / udv); r = 16'(udd % udv);
        end
`endif
    endfunction

    // Result check on every cycle Done is high
    always @(negedge Clk) begin
        if (chk_en && Reset === 1'b1 && Done === 1'b1) begin
            chk("quot", 32'(Quociente), 32'(exp_q));
            chk("rem", 32'(Resto), 32'(exp_r));
            chk("flags", {30'd0, DivZero, Overflow}, {30'd0, exp_dz, exp_ov});
`ifndef DIVISOR_SIGNED_EN
            if (!exp_dz && !exp_ov)
                chk("invariant", 32'(Quociente) * 32'(exp_dv) + 32'(Resto), exp_dd);
`endif
        end
    end

    // Called just after a negedge; returns at the negedge where the result is valid
    task automatic do_op(input logic [31:0] dd, input logic [15:0] dv, input bit hold);
        bit busy_ok;
        #1;
        Dividendo = dd;
        Divisor   = dv;
        St        = 1'b1;
        exp_dd    = dd;
        exp_dv    = dv;
        model(dd, dv, exp_q, exp_r, exp_dz, exp_ov, exp_fast);
        @(posedge Clk);
        #1;
        if (!hold) St = 1'b0;
        if (exp_fast) begin
            @(negedge Clk);
            chk("lat_fast", {30'd0, Done, Idle}, {30'd0, 1'b1, 1'b1});
        end else begin
            busy_ok = 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge Clk);
                if (Done !== 1'b0 || Idle !== 1'b0) busy_ok = 1'b0;
            end
            chk("busy", 32'(busy_ok), 32'd1);
            @(negedge Clk);
            chk("lat_done", {30'd0, Done, Idle}, {30'd0, 1'b1, 1'b1});
        end
    endtask

    initial begin
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mdz;
        logic        mov;
        logic        mfast;
        logic [31:0] rdd;
        logic [15:0] rdv;

        Reset = 1'b0; St = 1'b0; Dividendo = 32'd0; Divisor = 16'd0;
        exp_dd = 32'd0; exp_dv = 16'd0;
        #15;
        Reset = 1'b1;
        chk("rst_outs", {Quociente, Resto}, 32'd0);
        chk("rst_ctl", {28'd0, Idle, Done, DivZero, Overflow}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Pin the model with hand-computed values
        model(32'd100000, 16'd7, mq, mr, mdz, mov, mfast);
        chk("model_q", 32'(mq), 32'd14285);
        chk("model_r", 32'(mr), 32'd5);
        model(32'hFFFE0001, 16'hFFFF, mq, mr, mdz, mov, mfast);
        chk("model_max", {mq, mr}, {16'hFFFF, 16'h0000});

        @(negedge Clk);
        chk_en = 1'b1;

        do_op(32'd100000, 16'd7, 1'b0);
        chk("lit_100000_7", {Quociente, Resto}, {16'd14285, 16'd5});
        do_op(32'd1234, 16'd0, 1'b0);
        chk("lit_divzero", {Quociente, Resto}, {QUOT_ERR, 16'h04D2});
        chk("lit_dz_flag", {30'd0, DivZero, Overflow}, {30'd0, 1'b1, 1'b0});
        do_op(32'h00070000, 16'd7, 1'b0);
        chk("lit_ovf", {Quociente, Resto}, {QUOT_ERR, 16'h0000});
        chk("lit_ovf_flag", {30'd0, DivZero, Overflow}, {30'd0, 1'b0, 1'b1});
        do_op(32'hFFFE0001, 16'hFFFF, 1'b0);
        chk("lit_max", {Quociente, Resto, 14'd0, DivZero, Overflow}, {16'hFFFF, 16'h0000, 16'd0});

`ifdef DIVISOR_SIGNED_EN
        do_op(32'hFFFFFFF9, 16'd2, 1'b0);
        chk("lit_s_m7_2", {Quociente, Resto}, {16'hFFFD, 16'hFFFF});
        do_op(32'd7, 16'hFFFE, 1'b0);
        chk("lit_s_7_m2", {Quociente, Resto}, {16'hFFFD, 16'h0001});
        do_op(32'h80000000, 16'hFFFF, 1'b0);
        chk("lit_s_ovf", 32'(Overflow), 32'd1);
`endif

        // Back-to-back with St held high; Done must drop for exactly one cycle
        for (int i = 0; i < 65535; i += 4099) begin
            do_op(32'(i) * 32'd65535 + 32'(i % 65535), 16'hFFFF, 1'b1);
        end
        St = 1'b0;

        for (int n = 0; n < 60; n++) begin
            rdd = $urandom;
            rdv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rdv = 16'd0;
                1: rdd = {16'($urandom_range(0, 255)), rdd[15:0]};
                2: rdv = 16'($urandom_range(1, 15));
                default: rdd = rdd;
            endcase
            do_op(rdd, rdv, bit'($urandom_range(0, 1)));
        end
        St = 1'b0;

        // Abort an operation mid-CALC with the asynchronous reset
        @(negedge Clk);
        chk_en = 1'b0;
        #1;
        Dividendo = 32'd100000; Divisor = 16'd7; St = 1'b1;
        @(posedge Clk);
        #1;
        St = 1'b0;
        repeat (5) @(negedge Clk);
        chk("mid_busy", 32'(Idle), 32'd0);
        Reset = 1'b0;
        #1;
        chk("mid_rst_ctl", {28'd0, Idle, Done, DivZero, Overflow}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("mid_rst_outs", {Quociente, Resto}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        chk_en = 1'b1;

        do_op(32'd65535, 16'd256, 1'b0);
        chk("after_rst", {Quociente, Resto}, {16'd255, 16'd255});

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
